// File: rtl/local_net_if_if.sv
// Shared mesh parameters and the router link bundle that joins a node's
// network interface to the LOCAL port of its router.
package global_params;
  localparam int DATA_WIDTH = 8;
  localparam int MESH_SIDE  = 4;
  localparam int CW         = $clog2(MESH_SIDE);
endpackage

// Handshake: the source holds valid and every field stable until it sees ready;
// a flit moves on each rising clk edge where valid && ready are both high.
interface router_if;
  import global_params::*;
  logic [DATA_WIDTH-1:0] data;
  logic [CW-1:0]         dest_x;
  logic [CW-1:0]         dest_y;
  logic                  s_delta_x;
  logic                  s_delta_y;
  logic                  valid;
  logic                  ready;

  modport out_p (output data, dest_x, dest_y, s_delta_x, s_delta_y, valid, input ready);
  modport in_p  (input data, dest_x, dest_y, s_delta_x, s_delta_y, valid, output ready);
endinterface

// File: rtl/local_net_if.sv
// Core-side endpoint of a mesh router LOCAL port: TX FIFO + header FSM toward
// the router, destination-checked RX FIFO toward the core, plus statistics.
module local_net_if
  import global_params::*;
#(
  parameter int X_COORD   = 0,
  parameter int Y_COORD   = 0,
  parameter int TX_DEPTH  = 4,
  parameter int RX_DEPTH  = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [CW-1:0]         tx_dest_x,
  input  logic [CW-1:0]         tx_dest_y,
  router_if.out_p               to_router,
  router_if.in_p                from_router,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic [CNT_WIDTH-1:0]  tx_cnt,
  output logic [CNT_WIDTH-1:0]  rx_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic                  misroute,
  output logic                  tx_state_dbg
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0]        MY_X   = CW'(X_COORD);
  localparam logic [CW-1:0]        MY_Y   = CW'(Y_COORD);
  localparam logic [TAW:0]         TX_ONE = (TAW+1)'(1);
  localparam logic [RAW:0]         RX_ONE = (RAW+1)'(1);
  localparam logic [CNT_WIDTH-1:0] C_ONE  = CNT_WIDTH'(1);

  typedef enum logic {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_t;
  tx_state_t tx_state;

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0] tx_mem_d [TX_DEPTH];
  logic [CW-1:0]         tx_mem_x [TX_DEPTH];
  logic [CW-1:0]         tx_mem_y [TX_DEPTH];
  logic [TAW:0]          tx_wr, tx_rd;
  logic                  tx_empty, tx_full, tx_push, tx_pop, tx_xfer;

  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[TAW] != tx_rd[TAW]) && (tx_wr[TAW-1:0] == tx_rd[TAW-1:0]);
  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;
  assign tx_xfer  = (tx_state == TX_SEND) && to_router.ready;
  // The output register refills whenever it is empty or its flit leaves this edge.
  assign tx_pop   = !tx_empty && ((tx_state == TX_IDLE) || to_router.ready);

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem_d[tx_wr[TAW-1:0]] <= tx_data;
      tx_mem_x[tx_wr[TAW-1:0]] <= tx_dest_x;
      tx_mem_y[tx_wr[TAW-1:0]] <= tx_dest_y;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) tx_wr <= '0;
    else if (tx_push) tx_wr <= tx_wr + TX_ONE;
  end

  // ---------------- TX FSM + output register ----------------
  logic [DATA_WIDTH-1:0] out_data;
  logic [CW-1:0]         out_x, out_y;
  logic                  out_sdx, out_sdy, out_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state  <= TX_IDLE;
      tx_rd     <= '0;
      out_data  <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_sdx   <= 1'b0;
      out_sdy   <= 1'b0;
      out_valid <= 1'b0;
      tx_cnt    <= '0;
    end else begin
      if (tx_xfer) tx_cnt <= tx_cnt + C_ONE;
      if (tx_pop) begin
        tx_state  <= TX_SEND;
        tx_rd     <= tx_rd + TX_ONE;
        out_data  <= tx_mem_d[tx_rd[TAW-1:0]];
        out_x     <= tx_mem_x[tx_rd[TAW-1:0]];
        out_y     <= tx_mem_y[tx_rd[TAW-1:0]];
        out_sdx   <= (tx_mem_x[tx_rd[TAW-1:0]] < MY_X);
        out_sdy   <= (tx_mem_y[tx_rd[TAW-1:0]] < MY_Y);
        out_valid <= 1'b1;
      end else if (tx_xfer) begin
        tx_state  <= TX_IDLE;
        out_valid <= 1'b0;
      end
    end
  end

  assign to_router.data      = out_data;
  assign to_router.dest_x    = out_x;
  assign to_router.dest_y    = out_y;
  assign to_router.s_delta_x = out_sdx;
  assign to_router.s_delta_y = out_sdy;
  assign to_router.valid     = out_valid;
  assign tx_state_dbg        = (tx_state == TX_SEND);

  // ---------------- RX path ----------------
  logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
  logic [RAW:0]          rx_wr, rx_rd;
  logic                  rx_empty, rx_full, in_xfer, in_match, rx_push, rx_pop;

  assign rx_empty          = (rx_wr == rx_rd);
  assign rx_full           = (rx_wr[RAW] != rx_rd[RAW]) && (rx_wr[RAW-1:0] == rx_rd[RAW-1:0]);
  assign from_router.ready = !rx_full;
  assign in_xfer           = from_router.valid && !rx_full;
  assign in_match          = (from_router.dest_x == MY_X) && (from_router.dest_y == MY_Y);
  assign rx_push           = in_xfer && in_match;
  assign rx_pop            = !rx_empty && rx_ready;
  assign rx_valid          = !rx_empty;
  assign rx_data           = rx_mem[rx_rd[RAW-1:0]];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr[RAW-1:0]] <= from_router.data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_cnt   <= '0;
      drop_cnt <= '0;
      misroute <= 1'b0;
    end else begin
      if (rx_push) begin
        rx_wr  <= rx_wr + RX_ONE;
        rx_cnt <= rx_cnt + C_ONE;
      end
      // A misaddressed flit is still accepted so the router link never stalls on it.
      if (in_xfer && !in_match) begin
        drop_cnt <= drop_cnt + C_ONE;
        misroute <= 1'b1;
      end
      if (rx_pop) rx_rd <= rx_rd + RX_ONE;
    end
  end
endmodule

// File: tb/tb_local_net_if.sv
// Bench for local_net_if at node (1,2) of a 4x4 mesh: directed scenarios then
// randomized traffic, checked by scoreboards fed from a reference model.
module tb_local_net_if;
  import global_params::*;
  localparam int XC = 1;
  localparam int YC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx_valid = 1'b0;
  logic tx_ready;
  logic [DATA_WIDTH-1:0] tx_data = '0;
  logic [CW-1:0] tx_dest_x = '0, tx_dest_y = '0;
  logic rx_valid;
  logic rx_ready = 1'b0;
  logic [DATA_WIDTH-1:0] rx_data;
  logic [15:0] tx_cnt, rx_cnt, drop_cnt;
  logic misroute, tx_state_dbg;

  router_if to_r ();
  router_if from_r ();

  local_net_if #(.X_COORD(XC), .Y_COORD(YC), .TX_DEPTH(4), .RX_DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_dest_x(tx_dest_x), .tx_dest_y(tx_dest_y),
    .to_router(to_r), .from_router(from_r),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .drop_cnt(drop_cnt),
    .misroute(misroute), .tx_state_dbg(tx_state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic mon_en = 1'b0;
  logic [13:0] tx_q[$];               // {data, dest_x, dest_y, s_delta_x, s_delta_y}
  logic [DATA_WIDTH-1:0] exp_q[$];     // RX payloads expected at the core
  int exp_tx_cnt = 0, exp_rx_cnt = 0, exp_drop = 0;
  logic exp_mis = 1'b0;
  logic prev_stall = 1'b0;
  logic [13:0] prev_fields = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] model_flit(input logic [7:0] d, input int dx, input int dy);
    logic sdx, sdy;
    sdx = (dx < XC);
    sdy = (dy < YC);
    return {d, 2'(dx), 2'(dy), sdx, sdy};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      logic [13:0] cur;
      cur = {to_r.data, to_r.dest_x, to_r.dest_y, to_r.s_delta_x, to_r.s_delta_y};
      check("tx_cnt", 32'(tx_cnt), 32'(exp_tx_cnt[15:0]));
      check("rx_cnt", 32'(rx_cnt), 32'(exp_rx_cnt[15:0]));
      check("drop_cnt", 32'(drop_cnt), 32'(exp_drop[15:0]));
      check("misroute", 32'(misroute), 32'(exp_mis));
      if (prev_stall) begin
        check("stall_valid", 32'(to_r.valid), 32'd1);
        check("stall_fields", 32'(cur), 32'(prev_fields));
      end
      if (!rst) begin
        tx_q.delete();
        exp_q.delete();
        exp_tx_cnt = 0; exp_rx_cnt = 0; exp_drop = 0; exp_mis = 1'b0;
        prev_stall = 1'b0;
      end else begin
        prev_stall  = to_r.valid && !to_r.ready;
        prev_fields = cur;
        if (tx_valid && tx_ready)
          tx_q.push_back(model_flit(tx_data, int'(tx_dest_x), int'(tx_dest_y)));
        if (to_r.valid && to_r.ready) begin
          if (tx_q.size() == 0) check("tx_unexpected", 32'(cur), 32'hFFFF_FFFF);
          else check("tx_flit", 32'(cur), 32'(tx_q.pop_front()));
          exp_tx_cnt++;
        end
        if (from_r.valid && from_r.ready) begin
          if (int'(from_r.dest_x) == XC && int'(from_r.dest_y) == YC) begin
            exp_q.push_back(from_r.data);
            exp_rx_cnt++;
          end else begin
            exp_drop++;
            exp_mis = 1'b1;
          end
        end
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) check("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
          else check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] d, input int dx, input int dy);
    bit ok = 0;
    tx_valid = 1'b1; tx_data = d; tx_dest_x = 2'(dx); tx_dest_y = 2'(dy);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1; break; end
    end
    if (!ok) check("push_tx_timeout", 32'd0, 32'd1);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input int dx, input int dy);
    bit ok = 0;
    from_r.valid = 1'b1; from_r.data = d; from_r.dest_x = 2'(dx); from_r.dest_y = 2'(dy);
    from_r.s_delta_x = 1'b0; from_r.s_delta_y = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (from_r.ready) begin ok = 1; break; end
    end
    if (!ok) check("send_rx_timeout", 32'd0, 32'd1);
    tick();
    from_r.valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit tx_acc, in_acc, drained;
    to_r.ready = 1'b0;
    from_r.valid = 1'b0; from_r.data = '0; from_r.dest_x = '0; from_r.dest_y = '0;
    from_r.s_delta_x = 1'b0; from_r.s_delta_y = 1'b0;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_to_valid", 32'(to_r.valid), 32'd0);
    check("rst_from_ready", 32'(from_r.ready), 32'd1);

    // 1: single packet, latency and header
    tick();
    to_r.ready = 1'b1;
    push_tx(8'hA5, 3, 0);
    @(negedge clk);
    check("t1_valid_edge_n", 32'(to_r.valid), 32'd0);
    @(negedge clk);
    check("t1_valid_edge_n1", 32'(to_r.valid), 32'd1);
    check("t1_sdx", 32'(to_r.s_delta_x), 32'd0);
    check("t1_sdy", 32'(to_r.s_delta_y), 32'd1);
    @(negedge clk);
    check("t1_tx_cnt", 32'(tx_cnt), 32'd1);

    // 2: stall with 5 packets, then back-to-back drain
    tick();
    to_r.ready = 1'b0;
    for (int i = 0; i < 5; i++) push_tx(8'(8'h10 + i), i % 4, (i + 2) % 4);
    @(negedge clk);
    check("t2_tx_full", 32'(tx_ready), 32'd0);
    repeat (3) tick();
    to_r.ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_b2b_valid", 32'(to_r.valid), 32'd1);
    end
    @(negedge clk);
    check("t2_idle_after", 32'(to_r.valid), 32'd0);

    // 3: good inbound flit
    tick();
    rx_ready = 1'b1;
    send_rx(8'h3C, 1, 2);
    @(negedge clk);
    check("t3_rx_valid", 32'(rx_valid), 32'd1);
    check("t3_rx_data", 32'(rx_data), 32'h3C);
    check("t3_rx_cnt", 32'(rx_cnt), 32'd1);

    // 4: misrouted flit, misroute stays sticky
    tick();
    send_rx(8'h77, 0, 0);
    @(negedge clk);
    check("t4_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t4_misroute", 32'(misroute), 32'd1);
    tick();
    send_rx(8'h11, 1, 2);
    send_rx(8'h22, 1, 2);
    @(negedge clk);
    check("t4_misroute_sticky", 32'(misroute), 32'd1);

    // 5: RX backpressure
    tick();
    rx_ready = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) send_rx(8'(8'h50 + i), 1, 2);
    from_r.valid = 1'b1; from_r.data = 8'h54; from_r.dest_x = 2'd1; from_r.dest_y = 2'd2;
    @(negedge clk);
    check("t5_rx_full", 32'(from_r.ready), 32'd0);
    tick();
    rx_ready = 1'b1;
    send_rx(8'h54, 1, 2);
    repeat (8) tick();
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // 6: reset while SEND is stalled
    to_r.ready = 1'b0;
    push_tx(8'hE1, 2, 3);
    push_tx(8'hE2, 0, 1);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("t6_valid", 32'(to_r.valid), 32'd0);
    check("t6_state", 32'(tx_state_dbg), 32'd0);
    check("t6_tx_ready", 32'(tx_ready), 32'd1);
    check("t6_rx_valid", 32'(rx_valid), 32'd0);
    check("t6_tx_cnt", 32'(tx_cnt), 32'd0);
    check("t6_drop_cnt", 32'(drop_cnt), 32'd0);
    check("t6_misroute", 32'(misroute), 32'd0);

    // random traffic
    tick();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      tx_acc = tx_valid && tx_ready;
      in_acc = from_r.valid && from_r.ready;
      tick();
      if (!tx_valid || tx_acc) begin
        tx_valid  = ($urandom_range(0, 2) != 0);
        tx_data   = 8'($urandom);
        tx_dest_x = 2'($urandom_range(0, 3));
        tx_dest_y = 2'($urandom_range(0, 3));
      end
      to_r.ready = ($urandom_range(0, 3) != 0);
      if (!from_r.valid || in_acc) begin
        from_r.valid = ($urandom_range(0, 1) != 0);
        from_r.data  = 8'($urandom);
        if ($urandom_range(0, 3) != 0) begin
          from_r.dest_x = 2'(XC); from_r.dest_y = 2'(YC);
        end else begin
          from_r.dest_x = 2'($urandom_range(0, 3)); from_r.dest_y = 2'($urandom_range(0, 3));
        end
        from_r.s_delta_x = 1'($urandom_range(0, 1));
        from_r.s_delta_y = 1'($urandom_range(0, 1));
      end
      rx_ready = ($urandom_range(0, 3) != 0);
    end

    // drain
    tx_valid = 1'b0; from_r.valid = 1'b0; to_r.ready = 1'b1; rx_ready = 1'b1;
    drained = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx_q.size() == 0 && exp_q.size() == 0 && !to_r.valid && !rx_valid) begin
        drained = 1; break;
      end
    end
    check("drain_done", 32'(drained), 32'd1);
    @(negedge clk);
    check("final_tx_q_empty", 32'(tx_q.size()), 32'd0);
    check("final_rx_q_empty", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
